matrix3x3_gen: RTL
==================

# matrix3x3_gen

Streaming 3x3 window generator that produces the `matrix_p11`..`matrix_p33` neighbourhood and `start` strobe consumed by the downstream per-pixel stages, including double thresholding. It takes a raster pixel stream, stores the two previous image lines in line buffers, and shifts a 3x3 register window. It emits one window per accepted pixel whose position allows a full 3x3 neighbourhood.

## Interface
Parameters:
- `DW`, 16: pixel width in bits.
- `IMG_W`, 640: pixels per line, ≥3.
- `IMG_H`, 480: lines per frame, ≥3.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `pix_in`  in  DW: input pixel, raster order.
- `pix_valid`  in  1: `pix_in` is accepted this cycle.
- `sof`  in  1: start of frame; qualified by `pix_valid`; marks pixel (0,0).
- `matrix_p11`..`matrix_p33`  out  DW each: window. Row index is 1=oldest line, 3=current line. Column index is 1=oldest column, 3=newest column.
- `start`  out  1: window valid, one-cycle pulse per emitted window.

## Operation
- Counters: `col` in 0..IMG_W-1, `row` in 0..IMG_H-1. Both advance only on accepted pixels.
- When `col`==IMG_W-1, the next accepted pixel wraps `col` to 0 and increments `row`.
- `sof`&`pix_valid`: the pixel is taken as (0,0) regardless of counter state. An in-progress frame is abandoned and line buffer contents are treated as stale.
- After pixel (IMG_H-1, IMG_W-1), the block enters state DONE. Further pixels without `sof` are dropped: no shift, no `start`.
- States:
  - IDLE (after reset) → FILL on `sof`&`pix_valid`; pixels without `sof` in IDLE are dropped.
  - FILL (row<2) → RUN when row reaches 2.
  - RUN → DONE after the last pixel.
  - DONE → FILL on `sof`&`pix_valid`.
  - `sof`&`pix_valid` in any state → FILL with the pixel at (0,0).
- Line buffers: two, depth IMG_W. On each accepted pixel at column c:
  - Read lb1[c] (line r-1) and lb0[c] (line r-2).
  - Write lb1[c]←`pix_in` and lb0[c]←old lb1[c].
  - Read-before-write at the same address.
- Window shift on each accepted pixel: each row's column 1←column 2 and column 2←column 3. New column 3 = {lb0 read, lb1 read, `pix_in`} for rows {1, 2, 3}.
- `start` condition: registered, set in the cycle after accepting pixel (r,c) with r≥2 and c≥2.
  - The window then holds p33=(r,c), p32=(r,c-1), p31=(r,c-2), p2x=row r-1, p1x=row r-2, same columns.
- Columns 0 and 1 of each line shift normally, but `start` stays 0 because those windows straddle lines.
- Windows per frame: (IMG_H-2)*(IMG_W-2). No border padding.
- Matrix outputs hold their last value when `start`=0. They are undefined-but-stable during fill.

## Timing
- Latency: `start` and matrix outputs update exactly 1 cycle after the qualifying accepted pixel.
- Throughput: one pixel per cycle. Arbitrary `pix_valid` gaps are allowed; the window freezes during gaps.
- Back-to-back valid pixels in RUN at c≥2 give `start` high on consecutive cycles.
- Reset (any time, including mid-frame) asynchronously forces:
  - `start`=0, all matrix outputs=0, counters=0, state IDLE.
  - Line buffer contents need not be cleared.
- `sof` with the pixel that would complete a line: `sof` wins; no `start` results from that pixel.

## Configuration
- `MATRIX3X3_FRAME_DONE_EN`: when defined, adds output port `frame_done` (1 bit, reset 0).
  - `frame_done` pulses for one cycle, coincident with the `start` of the final window (IMG_H-1, IMG_W-1).
  - It is not asserted if the frame is abandoned by `sof` or reset.
- When undefined, the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `matrix_pkg` holds:
  - `DW` default and the pixel typedef (`logic [DW-1:0]`).
  - State enum {IDLE, FILL, RUN, DONE}.
  - Counter width helper ($clog2 of IMG_W/IMG_H).
- Sub-module `line_buf`: one line of depth IMG_W with single address, write enable, and combinational read-before-write old data.
- Two `line_buf` instances are chained. Counters, FSM and window registers live in the top.

## Test plan
- IMG_W=4, IMG_H=3, pixel=10*r+c, continuous valid, `sof` on first pixel:
  - Exactly 2 `start` pulses.
  - First window p11..p33 = 0,1,2,10,11,12,20,21,22.
  - Second window = 1,2,3,11,12,13,21,22,23.
- Same frame with random 0–3 cycle `pix_valid` gaps → identical 2 windows. Each `start` is 1 cycle after pixel 22 and 1 cycle after pixel 23.
- Frame followed by 5 extra pixels without `sof` → no `start`. Next `sof` frame → same 2 windows.
- `sof` reasserted at pixel (1,2) → prior frame abandoned. Full new frame gives exactly 2 correct windows.
- `rst` pulsed at pixel (2,2) → `start`=0 and matrix=0 immediately. Pixels without `sof` are dropped.
- With `MATRIX3X3_FRAME_DONE_EN`, IMG_W=5, IMG_H=4 → 6 `start` pulses. `frame_done` is high only with the 6th; absent under `sof` abort.

Source files
------------

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared pixel width, pixel type, FSM states and counter-width helper
// for the 3x3 window generator.
package matrix_pkg;
    localparam int DW = 16;
    typedef logic [DW-1:0] pix_t;
    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/line_buf.sv
// line_buf: one image line of storage; the read port returns the old word at the
// addressed column in the same cycle that a write replaces it.
module line_buf #(
    parameter int DW    = matrix_pkg::DW,
    parameter int DEPTH = 640
) (
    input  logic                                clk,
    input  logic                                i_we,
    input  logic [matrix_pkg::cnt_w(DEPTH)-1:0] i_addr,
    input  logic [DW-1:0]                       i_wdata,
    output logic [DW-1:0]                       o_rdata
);
    logic [DW-1:0] r_mem [DEPTH];
    always_ff @(posedge clk) if (i_we) r_mem[i_addr] <= i_wdata;
    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/matrix3x3_gen.sv
// matrix3x3_gen: streaming 3x3 window generator over two chained line buffers.
// Define MATRIX3X3_FRAME_DONE_EN to add the frame_done output.
module matrix3x3_gen #(
    parameter int DW    = matrix_pkg::DW,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] pix_in,
    input  logic          pix_valid,
    input  logic          sof,
    output logic [DW-1:0] matrix_p11,
    output logic [DW-1:0] matrix_p12,
    output logic [DW-1:0] matrix_p13,
    output logic [DW-1:0] matrix_p21,
    output logic [DW-1:0] matrix_p22,
    output logic [DW-1:0] matrix_p23,
    output logic [DW-1:0] matrix_p31,
    output logic [DW-1:0] matrix_p32,
    output logic [DW-1:0] matrix_p33,
    output logic          start
`ifdef MATRIX3X3_FRAME_DONE_EN
    ,
    output logic          frame_done
`endif
);
    import matrix_pkg::*;
    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    state_t r_state, w_state_nxt;
    logic [CW-1:0] r_col, w_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row, w_row_nxt;
    logic w_sof, w_take, w_last, w_start_nxt;
    logic [DW-1:0] w_lb0_rd, w_lb1_rd;
    logic [2:0][2:0][DW-1:0] r_win, w_win_nxt, r_mat;
    logic r_start;

    // lb1 holds line r-1; its displaced word cascades into lb0 as line r-2
    line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb1 (
        .clk(clk), .i_we(w_take), .i_addr(w_col), .i_wdata(pix_in), .o_rdata(w_lb1_rd)
    );
    line_buf #(.DW(DW), .DEPTH(IMG_W)) u_lb0 (
        .clk(clk), .i_we(w_take), .i_addr(w_col), .i_wdata(w_lb1_rd), .o_rdata(w_lb0_rd)
    );

    always_comb begin
        w_sof       = pix_valid && sof;
        w_take      = w_sof || (pix_valid && (r_state == FILL || r_state == RUN));
        w_col       = w_sof ? '0 : r_col;
        w_row       = w_sof ? '0 : r_row;
        w_last      = (w_row == ROW_LAST) && (w_col == COL_LAST);
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_state_nxt = r_state;
        if (w_take) begin
            w_col_nxt   = (w_col == COL_LAST) ? '0 : w_col + 1'b1;
            w_row_nxt   = w_last ? '0 : (w_col == COL_LAST) ? w_row + 1'b1 : w_row;
            w_state_nxt = w_last ? DONE : (w_row_nxt >= ROW_TWO) ? RUN : FILL;
        end
        w_start_nxt  = w_take && (w_row >= ROW_TWO) && (w_col >= COL_TWO);
        w_win_nxt[0] = {w_lb0_rd, r_win[0][2:1]};
        w_win_nxt[1] = {w_lb1_rd, r_win[1][2:1]};
        w_win_nxt[2] = {pix_in,   r_win[2][2:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
            r_row   <= '0;
            r_win   <= '0;
            r_mat   <= '0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_start <= w_start_nxt;
            if (w_take) r_win <= w_win_nxt;
            if (w_start_nxt) r_mat <= w_win_nxt;
        end
    end

`ifdef MATRIX3X3_FRAME_DONE_EN
    logic r_done;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_done <= 1'b0;
        else r_done <= w_start_nxt && w_last;
    end
    assign frame_done = r_done;
`endif

    assign start      = r_start;
    assign matrix_p11 = r_mat[0][0];
    assign matrix_p12 = r_mat[0][1];
    assign matrix_p13 = r_mat[0][2];
    assign matrix_p21 = r_mat[1][0];
    assign matrix_p22 = r_mat[1][1];
    assign matrix_p23 = r_mat[1][2];
    assign matrix_p31 = r_mat[2][0];
    assign matrix_p32 = r_mat[2][1];
    assign matrix_p33 = r_mat[2][2];
endmodule
